// File: rtl/mtr_drv_ctrl.sv
// mtr_drv_ctrl: converts signed left/right speed commands into 11-bit PWM duty
// words, applies slew-limited updates only at PWM period boundaries, and runs
// an over-current supervisor that latches a driver shutdown until cleared.
module mtr_drv_ctrl #(
  parameter int MAX_MAG      = 960,
  parameter int SLEW         = 16,
  parameter int MAX_OVR_PRDS = 8,
  parameter int CLR_PRDS     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               PWM_synch,
  input  logic               ovr_I_lft,
  input  logic               ovr_I_rght,
  input  logic               blank_lft,
  input  logic               blank_rght,
  input  logic               clr_shtdwn,
  output logic [10:0]        duty_lft,
  output logic [10:0]        duty_rght,
  output logic               drv_en,
  output logic               shtdwn,
  output logic [3:0]         bad_prds
);

  localparam int CW = $clog2(CLR_PRDS + 1);

  localparam logic [10:0]        MID_DUTY  = 11'h400;
  localparam logic signed [11:0] MAG_POS   = 12'(MAX_MAG);
  localparam logic signed [11:0] MAG_NEG   = -MAG_POS;
  localparam logic signed [12:0] SLEW_S    = 13'(SLEW);
  localparam logic [10:0]        SLEW_U    = 11'(SLEW);
  localparam logic [4:0]         TRIP_LVL  = 5'(MAX_OVR_PRDS);
  localparam logic [CW-1:0]      CLR_LAST  = CW'(CLR_PRDS - 1);
  localparam logic [CW-1:0]      CLEAN_ONE = CW'(1);
  localparam logic [CW-1:0]      CLEAN_0   = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SHTDWN = 2'd2,
    ARM    = 2'd3
  } state_t;

  // Clip a speed command to +/-MAX_MAG and offset it around mid-scale duty.
  function automatic logic [10:0] spd_to_target(input logic signed [11:0] spd);
    logic signed [11:0] sat;
    logic signed [11:0] sum;
    if (spd > MAG_POS) begin
      sat = MAG_POS;
    end else if (spd < MAG_NEG) begin
      sat = MAG_NEG;
    end else begin
      sat = spd;
    end
    sum = 12'sh400 + sat;
    return sum[10:0];
  endfunction

  // Move cur toward tgt by at most SLEW; snap onto tgt when within reach.
  function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [12:0] diff;
    logic [10:0]        res;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (diff > SLEW_S) begin
      res = cur + SLEW_U;
    end else if (diff < -SLEW_S) begin
      res = cur - SLEW_U;
    end else begin
      res = tgt;
    end
    return res;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [10:0]   duty_lft_r, duty_lft_nxt_s;
  logic [10:0]   duty_rght_r, duty_rght_nxt_s;
  logic [3:0]    bad_prds_r, bad_prds_nxt_s, bad_inc_s;
  logic [CW-1:0] clean_cnt_r, clean_cnt_nxt_s;
  logic          flt_r, flt_nxt_s;
  logic          flt_evt_s;
  logic          drv_en_r, shtdwn_r;

  assign flt_evt_s = (ovr_I_lft & ~blank_lft) | (ovr_I_rght & ~blank_rght);
  assign bad_inc_s = (bad_prds_r == 4'hF) ? 4'hF : (bad_prds_r + 4'd1);

  // Next-state, duty slew, fault flag and period accounting.
  always_comb begin
    state_nxt_s     = state_r;
    duty_lft_nxt_s  = duty_lft_r;
    duty_rght_nxt_s = duty_rght_r;
    bad_prds_nxt_s  = bad_prds_r;
    clean_cnt_nxt_s = clean_cnt_r;
    // A fault seen in the synch cycle belongs to the period that is starting.
    if (PWM_synch) begin
      flt_nxt_s = flt_evt_s;
    end else begin
      flt_nxt_s = flt_r | flt_evt_s;
    end

    case (state_r)
      IDLE: begin
        duty_lft_nxt_s  = MID_DUTY;
        duty_rght_nxt_s = MID_DUTY;
        if (PWM_synch) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (PWM_synch) begin
          duty_lft_nxt_s  = slew_step(duty_lft_r, spd_to_target(lft_spd));
          duty_rght_nxt_s = slew_step(duty_rght_r, spd_to_target(rght_spd));
          if (flt_r) begin
            bad_prds_nxt_s  = bad_inc_s;
            clean_cnt_nxt_s = CLEAN_0;
            if ({1'b0, bad_inc_s} >= TRIP_LVL) begin
              // Trip: park duties at mid-scale together with the state change.
              state_nxt_s     = SHTDWN;
              duty_lft_nxt_s  = MID_DUTY;
              duty_rght_nxt_s = MID_DUTY;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (clean_cnt_r == CLR_LAST) begin
            bad_prds_nxt_s  = 4'd0;
            clean_cnt_nxt_s = CLEAN_0;
          end else begin
            clean_cnt_nxt_s = clean_cnt_r + CLEAN_ONE;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      SHTDWN: begin
        duty_lft_nxt_s  = MID_DUTY;
        duty_rght_nxt_s = MID_DUTY;
        bad_prds_nxt_s  = 4'd0;
        clean_cnt_nxt_s = CLEAN_0;
        flt_nxt_s       = 1'b0;
        if (clr_shtdwn) begin
          state_nxt_s = ARM;
        end else begin
          state_nxt_s = SHTDWN;
        end
      end
      ARM: begin
        if (PWM_synch) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = ARM;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        duty_lft_nxt_s  = MID_DUTY;
        duty_rght_nxt_s = MID_DUTY;
        bad_prds_nxt_s  = 4'd0;
        clean_cnt_nxt_s = CLEAN_0;
        flt_nxt_s       = 1'b0;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      duty_lft_r  <= MID_DUTY;
      duty_rght_r <= MID_DUTY;
      bad_prds_r  <= 4'd0;
      clean_cnt_r <= CLEAN_0;
      flt_r       <= 1'b0;
      drv_en_r    <= 1'b0;
      shtdwn_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      duty_lft_r  <= duty_lft_nxt_s;
      duty_rght_r <= duty_rght_nxt_s;
      bad_prds_r  <= bad_prds_nxt_s;
      clean_cnt_r <= clean_cnt_nxt_s;
      flt_r       <= flt_nxt_s;
      drv_en_r    <= (state_nxt_s == RUN);
      shtdwn_r    <= (state_nxt_s == SHTDWN);
    end
  end

  assign duty_lft  = duty_lft_r;
  assign duty_rght = duty_rght_r;
  assign drv_en    = drv_en_r;
  assign shtdwn    = shtdwn_r;
  assign bad_prds  = bad_prds_r;

endmodule

// File: tb/tb_mtr_drv_ctrl.sv
// tb_mtr_drv_ctrl: randomized stimulus with a period-level reference model;
// expectations are queued by the driver and checked by independent monitors.
module tb_mtr_drv_ctrl;

  localparam int PER      = 24;
  localparam int MAX_MAG  = 960;
  localparam int SLEW     = 16;
  localparam int MAX_OVR  = 8;
  localparam int CLR_PRDS = 32;
  localparam int M_IDLE = 0, M_RUN = 1, M_SHUT = 2, M_ARM = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [11:0] lft_spd = 12'sd0;
  logic signed [11:0] rght_spd = 12'sd0;
  logic               PWM_synch = 1'b0;
  logic               ovr_I_lft = 1'b0, ovr_I_rght = 1'b0;
  logic               blank_lft = 1'b0, blank_rght = 1'b0;
  logic               clr_shtdwn = 1'b0;
  logic [10:0]        duty_lft, duty_rght;
  logic               drv_en, shtdwn;
  logic [3:0]         bad_prds;

  mtr_drv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .PWM_synch(PWM_synch), .ovr_I_lft(ovr_I_lft), .ovr_I_rght(ovr_I_rght),
    .blank_lft(blank_lft), .blank_rght(blank_rght), .clr_shtdwn(clr_shtdwn),
    .duty_lft(duty_lft), .duty_rght(duty_rght), .drv_en(drv_en),
    .shtdwn(shtdwn), .bad_prds(bad_prds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    dl;
    int    dr;
    int    en;
    int    sd;
    int    bad;
    string tag;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    m_mode, m_dl, m_dr, m_bad, m_clean;
  bit    m_flt;
  int    ls_cmd = 0, rs_cmd = 0;
  string cur_tag = "init";

  function automatic int clip_target(input int s);
    int c;
    c = (s > MAX_MAG) ? MAX_MAG : ((s < -MAX_MAG) ? -MAX_MAG : s);
    return 1024 + c;
  endfunction

  function automatic int approach(input int d, input int t);
    if (t - d > SLEW) return d + SLEW;
    if (d - t > SLEW) return d - SLEW;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_dl = 1024; m_dr = 1024; m_bad = 0; m_clean = 0; m_flt = 1'b0;
  endtask

  // Reference behaviour for one clock edge given that cycle's inputs.
  task automatic model_edge(input int ls, input int rs, input bit syn, input bit fevt, input bit clr);
    bit old_flt;
    old_flt = m_flt;
    m_flt = syn ? fevt : (m_flt | fevt);
    case (m_mode)
      M_IDLE: if (syn) m_mode = M_RUN;
      M_RUN: if (syn) begin
        m_dl = approach(m_dl, clip_target(ls));
        m_dr = approach(m_dr, clip_target(rs));
        if (old_flt) begin
          m_clean = 0;
          m_bad = (m_bad < 15) ? m_bad + 1 : 15;
          if (m_bad >= MAX_OVR) begin
            m_mode = M_SHUT; m_dl = 1024; m_dr = 1024;
          end
        end else begin
          m_clean++;
          if (m_clean == CLR_PRDS) begin
            m_clean = 0; m_bad = 0;
          end
        end
      end
      M_SHUT: begin
        m_flt = 1'b0; m_bad = 0; m_clean = 0; m_dl = 1024; m_dr = 1024;
        if (clr) m_mode = M_ARM;
      end
      M_ARM: if (syn) m_mode = M_RUN;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.dl = m_dl; e.dr = m_dr; e.bad = m_bad; e.tag = tag;
    e.en = (m_mode == M_RUN) ? 1 : 0;
    e.sd = (m_mode == M_SHUT) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  // One clock cycle of stimulus; speeds are random except in the synch cycle.
  task automatic cyc(input bit syn, input bit ol, input bit bl, input bit orr, input bit br, input bit clr);
    @(negedge clk);
    PWM_synch = syn; ovr_I_lft = ol; blank_lft = bl;
    ovr_I_rght = orr; blank_rght = br; clr_shtdwn = clr;
    if (syn) begin
      lft_spd = 12'(ls_cmd); rght_spd = 12'(rs_cmd);
    end else begin
      lft_spd = 12'($urandom); rght_spd = 12'($urandom);
    end
    model_edge(ls_cmd, rs_cmd, syn, (ol & ~bl) | (orr & ~br), clr);
    if (syn || clr) push_exp(cur_tag);
  endtask

  // One PWM period. fmode: 0 clean, 1 fault only while blanked,
  // 2 one unblanked right pulse, 4 random noise.
  task automatic period(input int fmode, input int clr_at);
    int hit;
    hit = $urandom_range(6, PER - 2);
    for (int c = 0; c < PER; c++) begin
      bit ol, bl, orr, br;
      bl = (c >= 1 && c <= 4); br = bl; ol = 1'b0; orr = 1'b0;
      case (fmode)
        1: ol = bl;
        2: orr = (c == hit);
        4: begin
          ol = ($urandom_range(0, 7) == 0); orr = ($urandom_range(0, 7) == 0);
          bl = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
        end
        default: ;
      endcase
      cyc(c == 0, ol, bl, orr, br, c == clr_at);
    end
  endtask

  task automatic periods(input int n, input int fmode);
    for (int i = 0; i < n; i++) period(fmode, -1);
  endtask

  // Quiet cycle, then sample just after the following edge.
  task automatic settle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    #2;
    model_reset();
    e.dl = 1024; e.dr = 1024; e.en = 0; e.sd = 0; e.bad = 0; e.tag = tag;
    sb_q.push_back(e);
    PWM_synch = 1'b0; clr_shtdwn = 1'b0; ovr_I_lft = 1'b0; ovr_I_rght = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "/duty_lft"}, int'(duty_lft), e.dl);
      chk({e.tag, "/duty_rght"}, int'(duty_rght), e.dr);
      chk({e.tag, "/drv_en"}, int'(drv_en), e.en);
      chk({e.tag, "/shtdwn"}, int'(shtdwn), e.sd);
      chk({e.tag, "/bad_prds"}, int'(bad_prds), e.bad);
    end
  endtask

  // Monitor: outputs after every synch or clear edge.
  always begin
    @(posedge clk);
    if (rst_n && (PWM_synch || clr_shtdwn)) begin
      #1;
      sb_check();
    end
  end

  // Monitor: outputs immediately after asynchronous reset assertion.
  always begin
    @(negedge rst_n);
    #1;
    sb_check();
  end

  // Watchdog against a stuck run.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cur_tag = "reset";
    do_reset(cur_tag);

    cur_tag = "ramp"; ls_cmd = 400; rs_cmd = -400;
    periods(10, 0);
    period(0, 7);
    periods(17, 0);
    settle();
    chk("ramp_lft_final", int'(duty_lft), 'h590);
    chk("ramp_rght_final", int'(duty_rght), 'h270);
    chk("ramp_drv_en", int'(drv_en), 1);

    cur_tag = "sat_pos"; ls_cmd = 2047; rs_cmd = -2048;
    periods(40, 0);
    settle();
    chk("sat_lft_max", int'(duty_lft), 'h7C0);
    chk("sat_rght_min", int'(duty_rght), 'h040);

    cur_tag = "sat_neg"; ls_cmd = -2048; rs_cmd = 2047;
    periods(125, 0);
    settle();
    chk("sat_lft_min", int'(duty_lft), 'h040);
    chk("sat_rght_max", int'(duty_rght), 'h7C0);

    cur_tag = "blanked"; ls_cmd = 100; rs_cmd = -50;
    periods(20, 1);
    settle();
    chk("blanked_bad", int'(bad_prds), 0);
    chk("blanked_shtdwn", int'(shtdwn), 0);

    cur_tag = "burst";
    periods(7, 2);
    periods(33, 0);
    settle();
    chk("burst_cleared_bad", int'(bad_prds), 0);
    periods(7, 2);
    periods(1, 0);
    settle();
    chk("burst2_bad", int'(bad_prds), 7);
    chk("burst2_no_shtdwn", int'(shtdwn), 0);

    cur_tag = "trip";
    periods(33, 0);
    periods(8, 2);
    periods(1, 0);
    periods(3, 4);
    settle();
    chk("trip_shtdwn", int'(shtdwn), 1);
    chk("trip_drv_en", int'(drv_en), 0);
    chk("trip_duty_lft", int'(duty_lft), 'h400);
    chk("trip_duty_rght", int'(duty_rght), 'h400);

    cur_tag = "release"; ls_cmd = 400; rs_cmd = -400;
    period(0, 5);
    periods(5, 0);
    settle();
    chk("rel_drv_en", int'(drv_en), 1);
    chk("rel_duty_lft", int'(duty_lft), 'h440);
    chk("rel_duty_rght", int'(duty_rght), 'h3C0);

    cur_tag = "mid_ramp_reset";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(cur_tag);

    cur_tag = "random";
    for (int p = 0; p < 150; p++) begin
      int fm, ca;
      ls_cmd = int'($urandom_range(0, 4095)) - 2048;
      rs_cmd = int'($urandom_range(0, 4095)) - 2048;
      fm = $urandom_range(0, 4);
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PER - 1)) : -1;
      period(fm, ca);
      if (p == 120) begin
        cur_tag = "random_reset";
        do_reset(cur_tag);
        cur_tag = "random";
      end
    end

    settle();
    #5;
    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
